// File: rtl/ddr3_ddl_pkg.sv
// rtl/ddr3_ddl_pkg.sv - command codes, DFI pin encodings, burst and timing constants for the DDR3 data-link layer
package ddr3_ddl_pkg;

    // Command codes presented by the controller FSM on ctl_cmd_i
    typedef enum logic [2:0] {
        CMD_NOP   = 3'b000,
        CMD_WRITE = 3'b001,
        CMD_READ  = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_PRE   = 3'b100,
        CMD_REF   = 3'b101
    } ddl_cmd_e;

    // DFI command pins as {ras_n, cas_n, we_n}
    localparam logic [2:0] PINS_NOP   = 3'b111;
    localparam logic [2:0] PINS_ACT   = 3'b011;
    localparam logic [2:0] PINS_READ  = 3'b101;
    localparam logic [2:0] PINS_WRITE = 3'b100;
    localparam logic [2:0] PINS_PRE   = 3'b010;
    localparam logic [2:0] PINS_REF   = 3'b001;

    // A BL8 burst is 4 DFI words since each DFI word carries 2 DDR beats
    localparam int BL8_BEATS  = 4;
    // The DQS strobe window covers the issue cycle plus the 4 data-slot cycles
    localparam int WSTB_BEATS = BL8_BEATS + 1;
    // Column-to-column spacing in clocks; also keeps READ and WRITE bursts apart
    localparam int T_CCD_CK   = 4;

    // Analogue timings in picoseconds so the conversion stays in integer math
    localparam int T_RCD_PS = 13750;
    localparam int T_RP_PS  = 13750;
    localparam int T_RFC_PS = 160000;
    localparam int T_WR_PS  = 15000;
    localparam int T_RTP_PS = 7500;

    // Width of the busy down-counter; comfortably holds tRFC at a few hundred MHz
    localparam int BUSY_W = 8;

    // Convert a time in ps to whole clocks, rounding up
    function automatic int ceil_cycles(input int t_ps, input int freq_mhz);
        int tck_ps;
        tck_ps = 1000000 / freq_mhz;
        return (t_ps + tck_ps - 1) / tck_ps;
    endfunction

    // Every command occupies at least its own issue cycle
    function automatic int at_least_one(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/ddr3_ddl_rdbuf.sv
// rtl/ddr3_ddl_rdbuf.sv - 4-entry first-word-fall-through read return FIFO
module ddr3_ddl_rdbuf
    import ddr3_ddl_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [BL8_BEATS];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == 3'd0);
    assign full     = (count == 3'(BL8_BEATS));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; only written on an accepted push
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_ddl_ctrl.sv
// rtl/ddr3_ddl_ctrl.sv - DDR3 data-link layer between controller FSM and DFI PHY; optional read FIFO via DDR3_DDL_RDBUF_EN
module ddr3_ddl_ctrl
    import ddr3_ddl_pkg::*;
#(
    parameter int DDR_FREQ_MHZ   = 100,
    parameter int DDR_ROW_BITS   = 13,
    parameter int DDR_COL_BITS   = 10,
    parameter int DFI_DATA_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ddr_cke_i,
    input  logic                        ddr_cs_ni,
    input  logic                        ctl_req_i,
    output logic                        ctl_rdy_o,
    input  logic [2:0]                  ctl_cmd_i,
    input  logic [2:0]                  ctl_ba_i,
    input  logic [DDR_ROW_BITS-1:0]     ctl_adr_i,
    input  logic                        mem_wvalid_i,
    output logic                        mem_wready_o,
    input  logic                        mem_wlast_i,
    input  logic [DFI_DATA_WIDTH/8-1:0] mem_wrmask_i,
    input  logic [DFI_DATA_WIDTH-1:0]   mem_wrdata_i,
    output logic                        mem_rvalid_o,
    input  logic                        mem_rready_i,
    output logic                        mem_rlast_o,
    output logic [DFI_DATA_WIDTH-1:0]   mem_rddata_o,
    output logic                        dfi_ras_no,
    output logic                        dfi_cas_no,
    output logic                        dfi_we_no,
    output logic [2:0]                  dfi_bank_o,
    output logic [DDR_ROW_BITS-1:0]     dfi_addr_o,
    output logic                        dfi_wstb_o,
    output logic                        dfi_wren_o,
    output logic [DFI_DATA_WIDTH/8-1:0] dfi_mask_o,
    output logic [DFI_DATA_WIDTH-1:0]   dfi_data_o,
    output logic                        dfi_rden_o,
    input  logic                        dfi_rvld_i,
    input  logic [DFI_DATA_WIDTH-1:0]   dfi_data_i
);

    localparam int MASKS = DFI_DATA_WIDTH / 8;
    // Auto-precharge flag sits directly above the column bits (A10 for a 10-bit column)
    localparam int AP_BIT = DDR_COL_BITS;

    localparam int N_ACT   = at_least_one(ceil_cycles(T_RCD_PS, DDR_FREQ_MHZ));
    localparam int N_PRE   = at_least_one(ceil_cycles(T_RP_PS, DDR_FREQ_MHZ));
    localparam int N_REF   = at_least_one(ceil_cycles(T_RFC_PS, DDR_FREQ_MHZ));
    localparam int N_RW    = at_least_one(T_CCD_CK);
    localparam int N_WR_AP = N_RW + ceil_cycles(T_WR_PS, DDR_FREQ_MHZ)
                                  + ceil_cycles(T_RP_PS, DDR_FREQ_MHZ);
    localparam int N_RD_AP = N_RW + ceil_cycles(T_RTP_PS, DDR_FREQ_MHZ)
                                  + ceil_cycles(T_RP_PS, DDR_FREQ_MHZ);
    localparam int N_NOP   = 1;

    // Counter loads are interval-1: the issue cycle itself is the first busy cycle
    localparam logic [BUSY_W-1:0] LD_ACT   = BUSY_W'(N_ACT - 1);
    localparam logic [BUSY_W-1:0] LD_PRE   = BUSY_W'(N_PRE - 1);
    localparam logic [BUSY_W-1:0] LD_REF   = BUSY_W'(N_REF - 1);
    localparam logic [BUSY_W-1:0] LD_RW    = BUSY_W'(N_RW - 1);
    localparam logic [BUSY_W-1:0] LD_WR_AP = BUSY_W'(N_WR_AP - 1);
    localparam logic [BUSY_W-1:0] LD_RD_AP = BUSY_W'(N_RD_AP - 1);
    localparam logic [BUSY_W-1:0] LD_NOP   = BUSY_W'(N_NOP - 1);

    logic [2:0]              pins;
    logic [2:0]              pins_nxt;
    logic [2:0]              bank_nxt;
    logic [DDR_ROW_BITS-1:0] addr_nxt;
    logic [BUSY_W-1:0]       busy;
    logic [BUSY_W-1:0]       busy_ld;
    logic                    is_write;
    logic                    is_read;
    logic                    accept;
    logic                    rd_block;
    logic [2:0]              wstb_cnt;
    logic [2:0]              wbeat_cnt;
    logic [2:0]              rbeat_cnt;
    logic [1:0]              ret_beat;
    logic                    unused;

    assign accept     = ctl_req_i & ctl_rdy_o & ~rd_block;
    assign dfi_ras_no = pins[2];
    assign dfi_cas_no = pins[1];
    assign dfi_we_no  = pins[0];

    // Decode the requested command into pin pattern, address and busy interval
    always_comb begin
        pins_nxt = PINS_NOP;
        bank_nxt = 3'd0;
        addr_nxt = '0;
        busy_ld  = LD_NOP;
        is_write = 1'b0;
        is_read  = 1'b0;
        case (ctl_cmd_i)
            CMD_ACT: begin
                pins_nxt = PINS_ACT;
                bank_nxt = ctl_ba_i;
                addr_nxt = ctl_adr_i;
                busy_ld  = LD_ACT;
            end
            CMD_READ: begin
                pins_nxt = PINS_READ;
                bank_nxt = ctl_ba_i;
                addr_nxt = ctl_adr_i;
                busy_ld  = ctl_adr_i[AP_BIT] ? LD_RD_AP : LD_RW;
                is_read  = 1'b1;
            end
            CMD_WRITE: begin
                pins_nxt = PINS_WRITE;
                bank_nxt = ctl_ba_i;
                addr_nxt = ctl_adr_i;
                busy_ld  = ctl_adr_i[AP_BIT] ? LD_WR_AP : LD_RW;
                is_write = 1'b1;
            end
            CMD_PRE: begin
                pins_nxt         = PINS_PRE;
                bank_nxt         = ctl_ba_i;
                addr_nxt[AP_BIT] = ctl_adr_i[AP_BIT];
                busy_ld          = LD_PRE;
            end
            CMD_REF: begin
                pins_nxt = PINS_REF;
                busy_ld  = LD_REF;
            end
            default: begin
                pins_nxt = PINS_NOP;
            end
        endcase
    end

    // Command issue: one-cycle pin pulse, busy countdown and registered ready
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pins       <= PINS_NOP;
            dfi_bank_o <= 3'd0;
            dfi_addr_o <= '0;
            busy       <= '0;
            ctl_rdy_o  <= 1'b0;
        end else if (accept) begin
            pins       <= pins_nxt;
            dfi_bank_o <= bank_nxt;
            dfi_addr_o <= addr_nxt;
            busy       <= busy_ld;
            ctl_rdy_o  <= 1'b0;
        end else begin
            pins       <= PINS_NOP;
            dfi_bank_o <= 3'd0;
            dfi_addr_o <= '0;
            busy       <= (busy == '0) ? busy : busy - 1'b1;
            ctl_rdy_o  <= (busy == '0) & ddr_cke_i & ~ddr_cs_ni;
        end
    end

    // Write strobe window: high from the issue cycle for WSTB_BEATS cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstb_cnt   <= 3'd0;
            dfi_wstb_o <= 1'b0;
        end else if (accept & is_write) begin
            wstb_cnt   <= 3'(WSTB_BEATS - 1);
            dfi_wstb_o <= 1'b1;
        end else if (wstb_cnt != 3'd0) begin
            wstb_cnt   <= wstb_cnt - 3'd1;
            dfi_wstb_o <= 1'b1;
        end else begin
            dfi_wstb_o <= 1'b0;
        end
    end

    // Memory-side write ready: one slot per BL8 beat, in the cycles after issue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbeat_cnt    <= 3'd0;
            mem_wready_o <= 1'b0;
        end else if (accept & is_write) begin
            wbeat_cnt    <= 3'(BL8_BEATS);
            mem_wready_o <= 1'b0;
        end else if (wbeat_cnt != 3'd0) begin
            wbeat_cnt    <= wbeat_cnt - 3'd1;
            mem_wready_o <= 1'b1;
        end else begin
            mem_wready_o <= 1'b0;
        end
    end

    // Write data pipeline: each ready slot becomes one DFI word; a missing beat is sent fully masked
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dfi_wren_o <= 1'b0;
            dfi_data_o <= '0;
            dfi_mask_o <= '0;
        end else if (mem_wready_o) begin
            dfi_wren_o <= 1'b1;
            dfi_data_o <= mem_wrdata_i;
            dfi_mask_o <= mem_wvalid_i ? mem_wrmask_i : {MASKS{1'b1}};
        end else begin
            dfi_wren_o <= 1'b0;
            dfi_data_o <= '0;
            dfi_mask_o <= '0;
        end
    end

    // Read enable window: one cycle per BL8 beat, in the cycles after issue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rbeat_cnt  <= 3'd0;
            dfi_rden_o <= 1'b0;
        end else if (accept & is_read) begin
            rbeat_cnt  <= 3'(BL8_BEATS);
            dfi_rden_o <= 1'b0;
        end else if (rbeat_cnt != 3'd0) begin
            rbeat_cnt  <= rbeat_cnt - 3'd1;
            dfi_rden_o <= 1'b1;
        end else begin
            dfi_rden_o <= 1'b0;
        end
    end

    // Returned-beat position within the current burst, used to flag the last beat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ret_beat <= 2'd0;
        end else if (dfi_rvld_i) begin
            ret_beat <= ret_beat + 2'd1;
        end
    end

`ifdef DDR3_DDL_RDBUF_EN
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [DFI_DATA_WIDTH:0] fifo_head;

    ddr3_ddl_rdbuf #(
        .WIDTH(DFI_DATA_WIDTH + 1)
    ) u_rdbuf (
        .clock     (clock),
        .reset     (reset),
        .push      (dfi_rvld_i),
        .push_data ({ret_beat == 2'd3, dfi_data_i}),
        .pop       (mem_rvalid_o & mem_rready_i),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign mem_rvalid_o = ~fifo_empty;
    assign mem_rlast_o  = ~fifo_empty & fifo_head[DFI_DATA_WIDTH];
    assign mem_rddata_o = fifo_head[DFI_DATA_WIDTH-1:0];
    // A new READ waits until every beat of the previous one has been taken
    assign rd_block     = (ctl_cmd_i == CMD_READ) & ~fifo_empty;
    assign unused       = mem_wlast_i | fifo_full;
`else
    // Read return: PHY data forwarded one register stage later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_rvalid_o <= 1'b0;
            mem_rlast_o  <= 1'b0;
            mem_rddata_o <= '0;
        end else begin
            mem_rvalid_o <= dfi_rvld_i;
            mem_rlast_o  <= dfi_rvld_i & (ret_beat == 2'd3);
            mem_rddata_o <= dfi_data_i;
        end
    end

    assign rd_block = 1'b0;
    // Burst length is fixed, so wlast carries no information; rready must be held high here
    assign unused   = mem_wlast_i | mem_rready_i;
`endif

endmodule

// File: tb/tb_ddr3_ddl_ctrl.sv
// tb/tb_ddr3_ddl_ctrl.sv - randomized self-checking bench for ddr3_ddl_ctrl against a timeline reference model
module tb_ddr3_ddl_ctrl;

    localparam int RB = 13;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TL = 4096;

    logic          clock = 1'b0;
    logic          reset;
    logic          cke, csn, req, rdy;
    logic [2:0]    cmd, ba;
    logic [RB-1:0] adr;
    logic          wvalid, wready, wlast;
    logic [MW-1:0] wrmask;
    logic [DW-1:0] wrdata;
    logic          rvalid, rready, rlast;
    logic [DW-1:0] rddata;
    logic          ras_n, cas_n, we_n;
    logic [2:0]    bank;
    logic [RB-1:0] addr;
    logic          wstb, wren, rden, rvld;
    logic [MW-1:0] mask;
    logic [DW-1:0] dfi_wdata, dfi_rdata;

    always #5 clock = ~clock;

    ddr3_ddl_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .ddr_cke_i    (cke),
        .ddr_cs_ni    (csn),
        .ctl_req_i    (req),
        .ctl_rdy_o    (rdy),
        .ctl_cmd_i    (cmd),
        .ctl_ba_i     (ba),
        .ctl_adr_i    (adr),
        .mem_wvalid_i (wvalid),
        .mem_wready_o (wready),
        .mem_wlast_i  (wlast),
        .mem_wrmask_i (wrmask),
        .mem_wrdata_i (wrdata),
        .mem_rvalid_o (rvalid),
        .mem_rready_i (rready),
        .mem_rlast_o  (rlast),
        .mem_rddata_o (rddata),
        .dfi_ras_no   (ras_n),
        .dfi_cas_no   (cas_n),
        .dfi_we_no    (we_n),
        .dfi_bank_o   (bank),
        .dfi_addr_o   (addr),
        .dfi_wstb_o   (wstb),
        .dfi_wren_o   (wren),
        .dfi_mask_o   (mask),
        .dfi_data_o   (dfi_wdata),
        .dfi_rden_o   (rden),
        .dfi_rvld_i   (rvld),
        .dfi_data_i   (dfi_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected output timeline, indexed by cycle number after reset release
    logic [2:0]    e_pins   [TL];
    logic [2:0]    e_bank   [TL];
    logic [RB-1:0] e_addr   [TL];
    bit            e_rden   [TL];
    bit            e_wstb   [TL];
    bit            e_wready [TL];
    bit            e_wren   [TL];
    logic [DW-1:0] e_wdata  [TL];
    logic [MW-1:0] e_wmask  [TL];
    bit            e_rvalid [TL];
    bit            e_rlast  [TL];
    logic [DW-1:0] e_rdata  [TL];
    int            busy_until;
    bit            exp_rdy;
    bit            last_acc;
    int            rbeats;

    // Whole clocks for a ps timing at 100 MHz (10 ns period), rounded up
    function automatic int ck(input int ps);
        return (ps + 9999) / 10000;
    endfunction

    function automatic int busy_len(input logic [2:0] c, input bit ap);
        int n;
        case (c)
            3'b011:  n = ck(13750);
            3'b100:  n = ck(13750);
            3'b101:  n = ck(160000);
            3'b010:  n = 4 + (ap ? ck(7500) + ck(13750) : 0);
            3'b001:  n = 4 + (ap ? ck(15000) + ck(13750) : 0);
            default: n = 1;
        endcase
        return (n < 1) ? 1 : n;
    endfunction

    function automatic logic [2:0] pins_of(input logic [2:0] c);
        case (c)
            3'b011:  return 3'b011;
            3'b010:  return 3'b101;
            3'b001:  return 3'b100;
            3'b100:  return 3'b010;
            3'b101:  return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < TL; i++) begin
            e_pins[i] = 3'b111; e_bank[i] = '0; e_addr[i] = '0;
            e_rden[i] = 0; e_wstb[i] = 0; e_wready[i] = 0; e_wren[i] = 0;
            e_wdata[i] = '0; e_wmask[i] = '0; e_rvalid[i] = 0; e_rlast[i] = 0; e_rdata[i] = '0;
        end
        cyc = 0; busy_until = -100; exp_rdy = 0; last_acc = 0; rbeats = 0;
    endtask

    task automatic check_reset_values();
        check("rst_pins", {ras_n, cas_n, we_n}, 3'b111);
        check("rst_bank", bank, 0);
        check("rst_addr", addr, 0);
        check("rst_mask", mask, 0);
        check("rst_data", dfi_wdata, 0);
        check("rst_wstb", wstb, 0);
        check("rst_wren", wren, 0);
        check("rst_rden", rden, 0);
        check("rst_rdy", rdy, 0);
        check("rst_wready", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
    endtask

    // Advance one clock: predict from the inputs of this cycle, then compare the next cycle
    task automatic tick();
        bit acc;
        logic [2:0] c_s, b_s;
        logic [RB-1:0] a_s;
        bit cke_s, csn_s;
        acc = req && exp_rdy;
        c_s = cmd; b_s = ba; a_s = adr; cke_s = cke; csn_s = csn;
        if (e_wready[cyc]) begin
            e_wren[cyc+1]  = 1;
            e_wdata[cyc+1] = wrdata;
            e_wmask[cyc+1] = wvalid ? wrmask : {MW{1'b1}};
        end
        if (rvld) begin
            e_rvalid[cyc+1] = 1;
            e_rdata[cyc+1]  = dfi_rdata;
            e_rlast[cyc+1]  = (rbeats % 4) == 3;
            rbeats++;
        end
        @(posedge clock);
        cyc++;
        last_acc = acc;
        if (acc) begin
            e_pins[cyc] = pins_of(c_s);
            case (c_s)
                3'b011, 3'b010, 3'b001: begin e_bank[cyc] = b_s; e_addr[cyc] = a_s; end
                3'b100: begin e_bank[cyc] = b_s; e_addr[cyc] = a_s & 13'h400; end
                default: ;
            endcase
            busy_until = cyc + busy_len(c_s, a_s[10]) - 1;
            if (c_s == 3'b001) begin
                for (int i = 0; i < 5; i++) e_wstb[cyc+i] = 1;
                for (int i = 1; i <= 4; i++) e_wready[cyc+i] = 1;
            end
            if (c_s == 3'b010) begin
                for (int i = 1; i <= 4; i++) e_rden[cyc+i] = 1;
            end
        end
        exp_rdy = (cyc > busy_until) && cke_s && !csn_s;
        @(negedge clock);
        check("rdy", rdy, exp_rdy);
        check("pins", {ras_n, cas_n, we_n}, e_pins[cyc]);
        check("bank", bank, e_bank[cyc]);
        check("addr", addr, e_addr[cyc]);
        check("rden", rden, e_rden[cyc]);
        check("wstb", wstb, e_wstb[cyc]);
        check("wready", wready, e_wready[cyc]);
        check("wren", wren, e_wren[cyc]);
        if (e_wren[cyc]) begin
            check("wdata", dfi_wdata, e_wdata[cyc]);
            check("wmask", mask, e_wmask[cyc]);
        end
        check("rvalid", rvalid, e_rvalid[cyc]);
        check("rlast", rlast, e_rlast[cyc]);
        if (e_rvalid[cyc]) check("rdata", rddata, e_rdata[cyc]);
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [RB-1:0] a);
        cmd = c; ba = b; adr = a; req = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (last_acc) break;
        end
        check("issue_accepted", last_acc, 1);
        req = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        #1;
        check_reset_values();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values();
        rvld = 0;
        reset = 0;
        clear_model();
    endtask

    initial begin
        reset = 1; cke = 1; csn = 0; req = 0; cmd = 0; ba = 0; adr = 0;
        wvalid = 0; wlast = 0; wrmask = 0; wrdata = 0; rready = 1; rvld = 0; dfi_rdata = 0;
        @(negedge clock);
        apply_reset();
        tick();

        // CKE low blocks commands and keeps the pins idle
        cke = 0; tick();
        cmd = 3'b011; req = 1;
        repeat (4) tick();
        req = 0; cke = 1;
        repeat (2) tick();

        // ACT bank 0 row 0
        issue(3'b011, 3'd0, 13'h000);
        repeat (3) tick();

        // READ bank 0 col 0, PHY returns A0..A3
        issue(3'b010, 3'd0, 13'h000);
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            rvld = 1; dfi_rdata = 32'hA0 + i;
            tick();
        end
        rvld = 0;
        repeat (3) tick();

        // WRITE col 8 with auto-precharge, data 0x11..0x44
        issue(3'b001, 3'd0, 13'h408);
        tick();
        for (int i = 0; i < 4; i++) begin
            wvalid = 1; wrmask = '0; wrdata = 32'h11 * (i + 1); wlast = (i == 3);
            tick();
        end
        wvalid = 0; wlast = 0;
        repeat (6) tick();

        // REF
        issue(3'b101, 3'd0, 13'h000);
        repeat (18) tick();

        // Reset in the middle of a write burst
        issue(3'b001, 3'd2, 13'h010);
        tick();
        wvalid = 1; wrdata = 32'hDEAD_BEEF;
        tick();
        apply_reset();
        wvalid = 0;
        tick();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cke       = ($urandom % 16) != 0;
            csn       = ($urandom % 16) == 0;
            req       = $urandom % 2;
            cmd       = $urandom % 8;
            ba        = $urandom % 8;
            adr       = $urandom;
            wvalid    = ($urandom % 4) != 0;
            wlast     = $urandom % 2;
            wrmask    = $urandom;
            wrdata    = $urandom;
            rvld      = ($urandom % 3) == 0;
            dfi_rdata = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
